load_writeback: RTL and testbench
=================================

Name: load_writeback

Overview:
- Executes RISC-V integer loads (LB/LH/LW/LBU/LHU) for the core.
- Issues a word-aligned read to the cache, waits for data, extracts and sign/zero-extends the addressed byte/halfword/word, and writes the result to the register file write port (rd, rd_write_enable, rd_data_in) as a single-cycle write.
- Sits between the decode/execute control and the registers block; the core stalls on busy.

Parameters:
- AddressBitWidth, 5, register index width; drives the width of rd_in and rd.
- MemAddressBitWidth, 32, byte address width to the cache.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  request a load; sampled only in IDLE
- address  input  MemAddressBitWidth  byte address of the load
- funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- rd_in  input  AddressBitWidth  destination register of the load
- busy  output  1  high from the cycle after an accepted start until the WRITE cycle inclusive
- done  output  1  one-cycle pulse in the WRITE cycle
- error  output  1  one-cycle pulse on a rejected request
- mem_address  output  MemAddressBitWidth  word-aligned address, {address[MSB:2],2'b00}
- mem_read_enable  output  1  read request to the cache; held until data is returned
- mem_data  input  32  read data word from the cache
- mem_data_ready  input  1  mem_data valid this cycle
- rd  output  AddressBitWidth  register write index
- rd_write_enable  output  1  register write strobe
- rd_data  output  32  register write data

Behaviour:
- Reset: state=IDLE. busy, done, error, mem_read_enable, rd_write_enable = 0. mem_address, rd, rd_data = 0.
- All outputs are registered. There is no combinational path from inputs to outputs.
- States: IDLE, WAIT_DATA, WRITE.
- IDLE, start=1, illegal funct3 (011,110,111): error=1 next cycle; stay IDLE; no memory access; no register write.
- IDLE, start=1, misaligned address (LH/LHU with address[0]=1; LW with address[1:0]!=0): same response as illegal funct3.
- IDLE, start=1, valid request:
  - Latch funct3, address[1:0] and rd_in.
  - Next cycle: mem_address = word address, mem_read_enable=1, busy=1, state=WAIT_DATA.
- WAIT_DATA: mem_read_enable and mem_address held stable. At the edge where mem_data_ready=1 is sampled:
  - mem_read_enable <= 0.
  - rd_data <= extracted value.
  - rd_write_enable <= (rd != 0).
  - done <= 1.
  - state <= WRITE.
- WRITE: lasts exactly one cycle. rd_write_enable and done fall, busy falls, state returns to IDLE.
- Load-to-load spacing: a new start is accepted only in IDLE, i.e. the cycle after done at the earliest.
- Extraction, offset = latched address[1:0]:
  - byte = mem_data[8*offset +: 8]
  - half = mem_data[16*offset[1] +: 16]
  - LB/LH: sign-extend to 32 bits. LBU/LHU: zero-extend. LW: the full word.
- rd=0: the load completes and done pulses; rd_write_enable stays 0.
- start while busy: ignored, with no side effects.
- mem_data_ready in IDLE or WRITE: ignored.
- Latency: start in cycle 0; mem_read_enable high from cycle 1. If ready is first sampled in cycle k (k>=1), the write and done occur in cycle k+1. Minimum is 2 cycles.
- No timeout: WAIT_DATA waits indefinitely.
- rst mid-operation: immediate return to IDLE with all outputs at reset values on the next cycle. Any in-flight cache response is discarded, and no register write occurs.

Decomposition:
- Shared package load_pkg:
  - funct3 constants: FUNCT3_LB, FUNCT3_LH, FUNCT3_LW, FUNCT3_LBU, FUNCT3_LHU.
  - state enum typedef: load_state_t {IDLE, WAIT_DATA, WRITE}.
- One combinational sub-module, load_extract (inputs: funct3, offset, word; output: 32-bit value). It is unit-testable on its own; the legality check stays in load_writeback.

Test Plan:
- LW address=0x100, cache returns 0xDEADBEEF 3 cycles after mem_read_enable, rd_in=5 -> mem_address=0x100; one-cycle rd_write_enable with rd=5, rd_data=0xDEADBEEF; done in the same cycle; busy high throughout.
- LB and LBU at address 0x203 with word 0x80FF7F01 -> LB gives 0xFFFFFF80; LBU gives 0x00000080; mem_address=0x200 both times.
- LH and LHU at 0x302 with word 0x8001_1234 -> LH gives 0xFFFF8001; LHU gives 0x00008001. LH at 0x301 -> error pulse, mem_read_enable never rises, no write.
- funct3=011 with any address -> error for one cycle, busy stays 0. LW with rd_in=0 -> done pulses, rd_write_enable stays 0.
- mem_data_ready already high in cycle 1 -> done in cycle 2. A second start asserted during WAIT_DATA is ignored; a start in the cycle after done is accepted.
- rst asserted in WAIT_DATA, then ready pulses -> all outputs 0 the next cycle, no register write, state IDLE; a subsequent LW completes normally.

Source files
------------

// File: rtl/load_pkg.sv
// Shared definitions for the load/writeback unit: funct3 load encodings,
// the control state type and the request legality helper.
package load_pkg;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    WRITE     = 2'd2
  } load_state_t;

  // A request is legal when funct3 names a supported load and the byte
  // offset is naturally aligned for the access size.
  function automatic logic load_request_ok(input logic [2:0] funct3,
                                           input logic [1:0] offset);
    logic ok_s;
    case (funct3)
      FUNCT3_LB, FUNCT3_LBU: ok_s = 1'b1;
      FUNCT3_LH, FUNCT3_LHU: ok_s = (offset[0] == 1'b0);
      FUNCT3_LW:             ok_s = (offset == 2'b00);
      default:               ok_s = 1'b0;
    endcase
    return ok_s;
  endfunction

endpackage

// File: rtl/load_writeback_if.sv
// Request, cache and register-write signals of the load unit.
// slave: the load unit itself; master: the core / cache / register side.
interface load_writeback_if #(
  parameter int AddressBitWidth    = 5,
  parameter int MemAddressBitWidth = 32
) ();

  logic                          start;
  logic [MemAddressBitWidth-1:0] address;
  logic [2:0]                    funct3;
  logic [AddressBitWidth-1:0]    rd_in;
  logic                          busy;
  logic                          done;
  logic                          error;
  logic [MemAddressBitWidth-1:0] mem_address;
  logic                          mem_read_enable;
  logic [31:0]                   mem_data;
  logic                          mem_data_ready;
  logic [AddressBitWidth-1:0]    rd;
  logic                          rd_write_enable;
  logic [31:0]                   rd_data;

  modport slave (
    input  start, address, funct3, rd_in, mem_data, mem_data_ready,
    output busy, done, error, mem_address, mem_read_enable,
           rd, rd_write_enable, rd_data
  );

  modport master (
    output start, address, funct3, rd_in, mem_data, mem_data_ready,
    input  busy, done, error, mem_address, mem_read_enable,
           rd, rd_write_enable, rd_data
  );

endinterface

// File: rtl/load_extract.sv
// Selects the addressed byte/halfword/word of a cache word and
// sign- or zero-extends it according to the load type.
module load_extract
  import load_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] value
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection: byte by full offset, halfword by offset[1].
  always_comb begin
    byte_s = word[{offset, 3'b000} +: 8];
    half_s = word[{offset[1], 4'b0000} +: 16];
  end

  // Extension according to the load type.
  always_comb begin
    case (funct3)
      FUNCT3_LB:  value = {{24{byte_s[7]}}, byte_s};
      FUNCT3_LBU: value = {24'h000000, byte_s};
      FUNCT3_LH:  value = {{16{half_s[15]}}, half_s};
      FUNCT3_LHU: value = {16'h0000, half_s};
      FUNCT3_LW:  value = word;
      default:    value = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_writeback.sv
// Load unit: validates a load request, issues a word-aligned cache read,
// waits for the data, extracts/extends it and writes it to the register
// file as a one-cycle strobe. All outputs come straight from flops.
module load_writeback
  import load_pkg::*;
#(
  parameter int AddressBitWidth    = 5,
  parameter int MemAddressBitWidth = 32
) (
  input logic             clk,
  input logic             rst,
  load_writeback_if.slave bus
);

  load_state_t                   state_r, state_nx_s;
  logic                          busy_r, busy_nx_s;
  logic                          done_r, done_nx_s;
  logic                          error_r, error_nx_s;
  logic [MemAddressBitWidth-1:0] mem_address_r, mem_address_nx_s;
  logic                          mem_read_enable_r, mem_read_enable_nx_s;
  logic [AddressBitWidth-1:0]    rd_r, rd_nx_s;
  logic                          rd_write_enable_r, rd_write_enable_nx_s;
  logic [31:0]                   rd_data_r, rd_data_nx_s;
  logic [2:0]                    funct3_r, funct3_nx_s;
  logic [1:0]                    offset_r, offset_nx_s;
  logic [31:0]                   extract_value_s;
  logic                          request_ok_s;

  load_extract u_extract (
    .funct3 (funct3_r),
    .offset (offset_r),
    .word   (bus.mem_data),
    .value  (extract_value_s)
  );

  // Legality of the request currently on the inputs.
  always_comb begin
    request_ok_s = load_request_ok(bus.funct3, bus.address[1:0]);
  end

  // Next-state and next-output logic; pulses default low, the rest holds.
  always_comb begin
    state_nx_s           = state_r;
    busy_nx_s            = busy_r;
    done_nx_s            = 1'b0;
    error_nx_s           = 1'b0;
    mem_address_nx_s     = mem_address_r;
    mem_read_enable_nx_s = mem_read_enable_r;
    rd_nx_s              = rd_r;
    rd_write_enable_nx_s = 1'b0;
    rd_data_nx_s         = rd_data_r;
    funct3_nx_s          = funct3_r;
    offset_nx_s          = offset_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          if (request_ok_s) begin
            state_nx_s           = WAIT_DATA;
            busy_nx_s            = 1'b1;
            mem_read_enable_nx_s = 1'b1;
            mem_address_nx_s     = {bus.address[MemAddressBitWidth-1:2], 2'b00};
            funct3_nx_s          = bus.funct3;
            offset_nx_s          = bus.address[1:0];
            rd_nx_s              = bus.rd_in;
          end else begin
            error_nx_s = 1'b1;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      WAIT_DATA: begin
        if (bus.mem_data_ready) begin
          state_nx_s           = WRITE;
          mem_read_enable_nx_s = 1'b0;
          rd_data_nx_s         = extract_value_s;
          rd_write_enable_nx_s = (rd_r != {AddressBitWidth{1'b0}});
          done_nx_s            = 1'b1;
        end else begin
          state_nx_s = WAIT_DATA;
        end
      end
      WRITE: begin
        state_nx_s = IDLE;
        busy_nx_s  = 1'b0;
      end
      default: begin
        state_nx_s           = IDLE;
        busy_nx_s            = 1'b0;
        mem_read_enable_nx_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r           <= IDLE;
      busy_r            <= 1'b0;
      done_r            <= 1'b0;
      error_r           <= 1'b0;
      mem_address_r     <= {MemAddressBitWidth{1'b0}};
      mem_read_enable_r <= 1'b0;
      rd_r              <= {AddressBitWidth{1'b0}};
      rd_write_enable_r <= 1'b0;
      rd_data_r         <= 32'h0000_0000;
      funct3_r          <= 3'b000;
      offset_r          <= 2'b00;
    end else begin
      state_r           <= state_nx_s;
      busy_r            <= busy_nx_s;
      done_r            <= done_nx_s;
      error_r           <= error_nx_s;
      mem_address_r     <= mem_address_nx_s;
      mem_read_enable_r <= mem_read_enable_nx_s;
      rd_r              <= rd_nx_s;
      rd_write_enable_r <= rd_write_enable_nx_s;
      rd_data_r         <= rd_data_nx_s;
      funct3_r          <= funct3_nx_s;
      offset_r          <= offset_nx_s;
    end
  end

  assign bus.busy            = busy_r;
  assign bus.done            = done_r;
  assign bus.error           = error_r;
  assign bus.mem_address     = mem_address_r;
  assign bus.mem_read_enable = mem_read_enable_r;
  assign bus.rd              = rd_r;
  assign bus.rd_write_enable = rd_write_enable_r;
  assign bus.rd_data         = rd_data_r;

endmodule

// File: tb/tb_load_writeback.sv
// Self-checking bench for load_writeback: directed cases followed by
// random loads compared against an arithmetic reference model.
module tb_load_writeback;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   we_count;

  load_writeback_if #(.AddressBitWidth(5), .MemAddressBitWidth(32)) bus ();

  load_writeback #(.AddressBitWidth(5), .MemAddressBitWidth(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count register write strobes seen by the register file.
  always @(negedge clk) begin
    if (bus.rd_write_enable === 1'b1) we_count = we_count + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_legal(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned a;
    a = addr;
    if (f3 == 3'd0 || f3 == 3'd4) return 1'b1;
    if (f3 == 3'd1 || f3 == 3'd5) return (a % 2) == 0;
    if (f3 == 3'd2) return (a % 4) == 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_value(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] word);
    int unsigned off;
    logic [31:0] b;
    logic [31:0] h;
    off = addr % 4;
    b = (word >> (8 * off)) & 32'h0000_00FF;
    h = (word >> (16 * (off / 2))) & 32'h0000_FFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd5:    return h;
      3'd2:    return word;
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Entered and left at a negedge with the unit idle.
  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rdi,
                         input logic [31:0] word, input int delay, input bit poke);
    bit          ok;
    logic [31:0] expv;
    int          we0;
    ok   = ref_legal(f3, addr);
    expv = ref_value(f3, addr, word);
    we0  = we_count;
    bus.start   = 1'b1;
    bus.funct3  = f3;
    bus.address = addr;
    bus.rd_in   = rdi;
    @(negedge clk);
    bus.start = 1'b0;
    if (!ok) begin
      chk("rej_error", {31'd0, bus.error}, 32'd1);
      chk("rej_busy", {31'd0, bus.busy}, 32'd0);
      chk("rej_mre", {31'd0, bus.mem_read_enable}, 32'd0);
      @(negedge clk);
      chk("rej_error_fall", {31'd0, bus.error}, 32'd0);
      chk("rej_mre2", {31'd0, bus.mem_read_enable}, 32'd0);
      chk("rej_no_write", we_count, we0);
      return;
    end
    chk("c1_busy", {31'd0, bus.busy}, 32'd1);
    chk("c1_mre", {31'd0, bus.mem_read_enable}, 32'd1);
    chk("c1_maddr", bus.mem_address, addr & 32'hFFFF_FFFC);
    chk("c1_error", {31'd0, bus.error}, 32'd0);
    for (int i = 0; i < delay; i++) begin
      if (poke) begin
        bus.start  = 1'b1;
        bus.funct3 = 3'b011;
        bus.rd_in  = ~rdi;
      end
      @(negedge clk);
      bus.start = 1'b0;
      chk("wait_mre", {31'd0, bus.mem_read_enable}, 32'd1);
      chk("wait_maddr", bus.mem_address, addr & 32'hFFFF_FFFC);
      chk("wait_done", {31'd0, bus.done}, 32'd0);
      chk("wait_error", {31'd0, bus.error}, 32'd0);
    end
    bus.mem_data       = word;
    bus.mem_data_ready = 1'b1;
    @(negedge clk);
    bus.mem_data_ready = 1'b0;
    bus.mem_data       = $urandom;
    chk("wr_done", {31'd0, bus.done}, 32'd1);
    chk("wr_busy", {31'd0, bus.busy}, 32'd1);
    chk("wr_mre", {31'd0, bus.mem_read_enable}, 32'd0);
    chk("wr_we", {31'd0, bus.rd_write_enable}, (rdi != 5'd0) ? 32'd1 : 32'd0);
    chk("wr_rd", {27'd0, bus.rd}, {27'd0, rdi});
    chk("wr_data", bus.rd_data, expv);
    @(negedge clk);
    chk("end_done", {31'd0, bus.done}, 32'd0);
    chk("end_busy", {31'd0, bus.busy}, 32'd0);
    chk("end_we", {31'd0, bus.rd_write_enable}, 32'd0);
    chk("end_we_count", we_count, we0 + ((rdi != 5'd0) ? 1 : 0));
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] addr;
    int          we0;
    checks   = 0;
    errors   = 0;
    we_count = 0;
    rst                = 1'b1;
    bus.start          = 1'b0;
    bus.address        = 32'h0;
    bus.funct3         = 3'b000;
    bus.rd_in          = 5'd0;
    bus.mem_data       = 32'h0;
    bus.mem_data_ready = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_error", {31'd0, bus.error}, 32'd0);
    chk("rst_mre", {31'd0, bus.mem_read_enable}, 32'd0);
    chk("rst_we", {31'd0, bus.rd_write_enable}, 32'd0);
    chk("rst_maddr", bus.mem_address, 32'd0);
    chk("rst_rd", {27'd0, bus.rd}, 32'd0);
    chk("rst_rd_data", bus.rd_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    do_load(3'b010, 32'h0000_0100, 5'd5, 32'hDEAD_BEEF, 2, 1'b0);
    do_load(3'b000, 32'h0000_0203, 5'd6, 32'h80FF_7F01, 1, 1'b0);
    do_load(3'b100, 32'h0000_0203, 5'd7, 32'h80FF_7F01, 1, 1'b0);
    do_load(3'b001, 32'h0000_0302, 5'd8, 32'h8001_1234, 0, 1'b0);
    do_load(3'b101, 32'h0000_0302, 5'd9, 32'h8001_1234, 0, 1'b0);
    do_load(3'b001, 32'h0000_0301, 5'd9, 32'h8001_1234, 0, 1'b0);
    do_load(3'b011, 32'h0000_0300, 5'd3, 32'h0, 0, 1'b0);
    do_load(3'b010, 32'h0000_0402, 5'd3, 32'h0, 0, 1'b0);
    do_load(3'b010, 32'h0000_0500, 5'd0, 32'h1234_5678, 1, 1'b0);
    do_load(3'b010, 32'h0000_0600, 5'd31, 32'hCAFE_F00D, 3, 1'b1);

    // Ready while idle is ignored.
    bus.mem_data_ready = 1'b1;
    @(negedge clk);
    bus.mem_data_ready = 1'b0;
    chk("idle_ready_done", {31'd0, bus.done}, 32'd0);
    chk("idle_ready_busy", {31'd0, bus.busy}, 32'd0);

    // Reset while waiting for data, then a late ready.
    we0 = we_count;
    bus.start   = 1'b1;
    bus.funct3  = 3'b010;
    bus.address = 32'h0000_0400;
    bus.rd_in   = 5'd7;
    @(negedge clk);
    bus.start = 1'b0;
    chk("pre_rst_mre", {31'd0, bus.mem_read_enable}, 32'd1);
    rst = 1'b1;
    bus.mem_data = 32'h1111_2222;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_mre", {31'd0, bus.mem_read_enable}, 32'd0);
    chk("midrst_maddr", bus.mem_address, 32'd0);
    chk("midrst_rd", {27'd0, bus.rd}, 32'd0);
    chk("midrst_rd_data", bus.rd_data, 32'd0);
    bus.mem_data_ready = 1'b1;
    @(negedge clk);
    bus.mem_data_ready = 1'b0;
    @(negedge clk);
    chk("midrst_done", {31'd0, bus.done}, 32'd0);
    chk("midrst_no_write", we_count, we0);
    do_load(3'b010, 32'h0000_0400, 5'd7, 32'h3333_4444, 1, 1'b0);

    // Random loads, including illegal and misaligned requests.
    for (int n = 0; n < 40; n++) begin
      f3   = 3'($urandom_range(0, 7));
      addr = $urandom;
      do_load(f3, addr, 5'($urandom_range(0, 31)), $urandom, $urandom_range(0, 3),
              1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
